// File: rtl/mem_ctrl.sv
// Byte-serial controller sharing the 8-bit RAM/IO bus between IF and LSU.
// Ports: clk_in/rst_in/rdy_in, IF and LSU request/done channels, mem_* bus,
// io_buffer_full back-pressure for IO stores.
module mem_ctrl #(
    parameter int RAM_ADDR_WIDTH = 17
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        if_req_in,
    input  logic [31:0] if_addr_in,
    input  logic        if_clear_in,
    output logic        if_done_out,
    output logic [31:0] if_data_out,
    input  logic        ls_req_in,
    input  logic        ls_wr_in,
    input  logic [31:0] ls_addr_in,
    input  logic [1:0]  ls_size_in,
    input  logic [31:0] ls_wdata_in,
    output logic        ls_done_out,
    output logic [31:0] ls_rdata_out,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    input  logic        io_buffer_full
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t      state_q, state_d;
    logic        own_ls_q, own_ls_d;
    logic        last_ls_q, last_ls_d;
    logic [31:0] base_q, base_d;
    logic [2:0]  len_q, len_d;
    logic [2:0]  iss_q, iss_d;
    logic [2:0]  cap_q, cap_d;
    logic [31:0] buf_q, buf_d;
    logic        if_done_q, if_done_d;
    logic        ls_done_q, ls_done_d;
    logic [31:0] if_data_q, if_data_d;
    logic [31:0] ls_data_q, ls_data_d;

    logic [31:0] cur_addr;
    logic        cur_io;
    logic [31:0] cap_buf;
    logic        if_req_v;
    logic        grant_ls;
    logic        ls_write;

    always_comb begin
        state_d   = state_q;
        own_ls_d  = own_ls_q;
        last_ls_d = last_ls_q;
        base_d    = base_q;
        len_d     = len_q;
        iss_d     = iss_q;
        cap_d     = cap_q;
        buf_d     = buf_q;
        if_done_d = 1'b0;
        ls_done_d = 1'b0;
        if_data_d = if_data_q;
        ls_data_d = ls_data_q;
        mem_wr    = 1'b0;
        mem_a     = 32'h0;
        mem_dout  = 8'h0;
        grant_ls  = 1'b0;
        ls_write  = 1'b0;

        cur_addr = base_q + {29'b0, iss_q};
        cur_io   = (cur_addr[RAM_ADDR_WIDTH:RAM_ADDR_WIDTH-1] == 2'b11);
        cap_buf  = buf_q;
        cap_buf[{cap_q[1:0], 3'b000} +: 8] = mem_din;
        // A flushed fetch must not be re-granted in the flush cycle.
        if_req_v = if_req_in & ~if_clear_in;

        if (!rdy_in) begin
            // Bus lost: freeze, and restart the transfer from byte 0 later.
            iss_d     = 3'd0;
            cap_d     = 3'd0;
            if_done_d = if_done_q;
            ls_done_d = ls_done_q;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (if_req_v || ls_req_in) begin
                        // On a tie the side not served last time wins.
                        grant_ls  = ls_req_in & (~if_req_v | ~last_ls_q);
                        ls_write  = grant_ls & ls_wr_in;
                        own_ls_d  = grant_ls;
                        last_ls_d = grant_ls;
                        base_d    = grant_ls ? ls_addr_in : if_addr_in;
                        if (!grant_ls || ls_size_in[1])
                            len_d = 3'd4;
                        else if (ls_size_in[0])
                            len_d = 3'd2;
                        else
                            len_d = 3'd1;
                        iss_d   = 3'd0;
                        cap_d   = 3'd0;
                        buf_d   = ls_write ? ls_wdata_in : 32'h0;
                        state_d = ls_write ? WRITE : READ;
                    end
                end
                READ: begin
                    if (iss_q < len_q) begin
                        mem_a = cur_addr;
                        iss_d = iss_q + 3'd1;
                    end
                    // Bytes issued but not yet captured are on mem_din now.
                    if (cap_q < iss_q) begin
                        buf_d = cap_buf;
                        cap_d = cap_q + 3'd1;
                        if (cap_q == len_q - 3'd1) begin
                            state_d = DONE;
                            if (own_ls_q) begin
                                ls_done_d = 1'b1;
                                ls_data_d = cap_buf;
                            end else begin
                                if_done_d = 1'b1;
                                if_data_d = cap_buf;
                            end
                        end
                    end
                    if (!own_ls_q && if_clear_in) begin
                        state_d   = IDLE;
                        if_done_d = 1'b0;
                        if_data_d = if_data_q;
                    end
                end
                WRITE: begin
                    if (!(cur_io && io_buffer_full)) begin
                        mem_wr   = 1'b1;
                        mem_a    = cur_addr;
                        mem_dout = buf_q[{iss_q[1:0], 3'b000} +: 8];
                        iss_d    = iss_q + 3'd1;
                        if (iss_q == len_q - 3'd1) begin
                            state_d   = DONE;
                            ls_done_d = own_ls_q;
                            if_done_d = ~own_ls_q;
                        end
                    end
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q   <= IDLE;
            own_ls_q  <= 1'b0;
            last_ls_q <= 1'b0;
            base_q    <= 32'h0;
            len_q     <= 3'd0;
            iss_q     <= 3'd0;
            cap_q     <= 3'd0;
            buf_q     <= 32'h0;
            if_done_q <= 1'b0;
            ls_done_q <= 1'b0;
            if_data_q <= 32'h0;
            ls_data_q <= 32'h0;
        end else begin
            state_q   <= state_d;
            own_ls_q  <= own_ls_d;
            last_ls_q <= last_ls_d;
            base_q    <= base_d;
            len_q     <= len_d;
            iss_q     <= iss_d;
            cap_q     <= cap_d;
            buf_q     <= buf_d;
            if_done_q <= if_done_d;
            ls_done_q <= ls_done_d;
            if_data_q <= if_data_d;
            ls_data_q <= ls_data_d;
        end
    end

    assign if_done_out  = if_done_q;
    assign ls_done_out  = ls_done_q;
    assign if_data_out  = if_data_q;
    assign ls_rdata_out = ls_data_q;

endmodule
